// File: rtl/bim_counter_table.sv
// Bimodal branch predictor table: 2^IDX_W saturating counters with a registered lookup,
// a pipelined read-modify-write update path, and a reset-triggered init sweep.
module bim_counter_table #(
    parameter int IDX_W    = 10,
    parameter int CTR_W    = 2,
    parameter int INIT_VAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_done,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [CTR_W-1:0] rd_ctr,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_VAL);
    localparam logic [IDX_W-1:0] PTR_LAST = {IDX_W{1'b1}};

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [CTR_W-1:0] mem [DEPTH];

    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             taken_p1;
    logic             vld_p2;
    logic [IDX_W-1:0] idx_p2;
    logic [CTR_W-1:0] val_p2;

    logic [CTR_W-1:0] old_p1;
    logic [CTR_W-1:0] new_p1;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [CTR_W-1:0] mem_wdata;
    logic [CTR_W-1:0] rd_data;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (v == CTR_MAX) ? v : v + CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] v);
        return (v == '0) ? v : v - CTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == PTR_LAST) state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign init_done = (state_q == ST_RUN);

    // Stage p1: capture the update request (dropped while sweeping)
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= upd_en && (state_q == ST_RUN);
        idx_p1   <= upd_idx;
        taken_p1 <= upd_taken;
    end

    // Forward from p2 so back-to-back updates to one index compose
    always_comb begin
        old_p1 = (vld_p2 && (idx_p2 == idx_p1)) ? val_p2 : mem[idx_p1];
        new_p1 = taken_p1 ? sat_inc(old_p1) : sat_dec(old_p1);
    end

    // Stage p2: modified counter waiting to be written back
    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
        idx_p2 <= idx_p1;
        val_p2 <= new_p1;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx_p2;
        mem_wdata = val_p2;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = CTR_INIT;
            end else if (vld_p2) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Lookup sees the pending write-back value so it is never stale by one cycle
    assign rd_data = (vld_p2 && (idx_p2 == rd_idx)) ? val_p2 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_ctr   <= '0;
        end else if (rd_en && (state_q == ST_RUN)) begin
            rd_valid <= 1'b1;
            rd_ctr   <= rd_data;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    assign rd_taken = rd_ctr[CTR_W-1];

endmodule

// File: tb/tb_bim_counter_table.sv
// Directed bench for bim_counter_table with IDX_W=4, CTR_W=2, INIT_VAL=1.
module tb_bim_counter_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic       rd_en;
    logic [3:0] rd_idx;
    logic       rd_valid;
    logic [1:0] rd_ctr;
    logic       rd_taken;
    logic       upd_en;
    logic [3:0] upd_idx;
    logic       upd_taken;

    int n_chk  = 0;
    int n_fail = 0;

    bim_counter_table #(
        .IDX_W   (4),
        .CTR_W   (2),
        .INIT_VAL(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .init_done(init_done),
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_ctr   (rd_ctr),
        .rd_taken (rd_taken),
        .upd_en   (upd_en),
        .upd_idx  (upd_idx),
        .upd_taken(upd_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [3:0] idx, input logic [1:0] exp);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, rd_valid, 1);
        chk({tag, "_ctr"}, rd_ctr, exp);
        chk({tag, "_tkn"}, rd_taken, exp[1]);
    endtask

    task automatic upd(input logic [3:0] idx, input logic taken);
        upd_en    = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        tick();
        upd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_sat [9];
        int cnt;
        exp_sat = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};

        rst = 1'b1; rd_en = 1'b0; rd_idx = '0;
        upd_en = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        tick();
        tick();
        chk("rst_init_done", init_done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_ctr", rd_ctr, 0);
        chk("rst_rd_taken", rd_taken, 0);

        // Sweep length after releasing reset
        rst = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (init_done) begin
                cnt = i;
                break;
            end
        end
        chk("init_cycles", cnt, 16);

        for (int i = 0; i < 16; i++) lookup($sformatf("init_idx%0d", i), 4'(i), 2'd1);
        tick();
        chk("idle_rd_valid", rd_valid, 0);
        chk("hold_rd_ctr", rd_ctr, 1);

        // Saturation in both directions on idx 5
        for (int i = 0; i < 9; i++) begin
            upd(4'd5, i < 4);
            tick();
            lookup($sformatf("sat%0d", i), 4'd5, exp_sat[i]);
        end

        // Forwarding: three back-to-back taken updates on idx 7
        upd(4'd7, 1'b1);
        upd(4'd7, 1'b1);
        upd(4'd7, 1'b1);
        tick();
        tick();
        lookup("fwd_idx7", 4'd7, 2'd3);

        upd(4'd9, 1'b1);
        upd(4'd9, 1'b0);
        upd(4'd9, 1'b1);
        tick();
        tick();
        lookup("fwd_idx9", 4'd9, 2'd2);

        // Ordering on idx 3
        upd(4'd3, 1'b1);
        lookup("ord_n1", 4'd3, 2'd1);
        lookup("ord_n2", 4'd3, 2'd2);
        tick();
        upd_en = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1;
        lookup("ord_same", 4'd3, 2'd2);
        upd_en = 1'b0;
        tick();
        lookup("ord_after", 4'd3, 2'd3);

        // Reset mid-operation with an update in flight on idx 2
        upd(4'd2, 1'b1);
        upd(4'd2, 1'b1);
        tick();
        tick();
        lookup("mid_pre", 4'd2, 2'd3);
        upd(4'd2, 1'b0);
        rst = 1'b1;
        rd_en = 1'b1; rd_idx = 4'd2;
        tick();
        rst = 1'b0;
        rd_en = 1'b0;
        chk("mid_rd_valid", rd_valid, 0);
        chk("mid_init_done", init_done, 0);

        // Updates and lookups during the sweep must be dropped
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            upd_en    = (i <= 5);
            upd_idx   = 4'd4;
            upd_taken = 1'b1;
            rd_en     = (i <= 5);
            rd_idx    = 4'd4;
            tick();
            if (init_done) begin
                cnt = i;
                break;
            end
            if (i <= 6) chk($sformatf("gate_rd_valid%0d", i), rd_valid, 0);
        end
        upd_en = 1'b0;
        rd_en  = 1'b0;
        chk("mid_init_cycles", cnt, 16);
        tick();
        tick();
        lookup("mid_idx2", 4'd2, 2'd1);
        lookup("gate_idx4", 4'd4, 2'd1);
        lookup("mid_idx5", 4'd5, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bim_counter_table.md
Name: bim_counter_table

Overview:
- Parametrised successor of the 2-bit bimodal predictor RAM: a 2^IDX_W-entry table of CTR_W-bit saturating counters.
- Lookup port: registered read with write bypass.
- Update port: takes only index plus taken/not-taken; the block runs a pipelined read-modify-write with forwarding.
- Reset starts an init-sweep FSM that writes every entry to INIT_VAL. Sits in the fetch-stage branch predictor beside the BTB.

Parameters:
- IDX_W, 10, index width; DEPTH = 2^IDX_W entries
- CTR_W, 2, counter width in bits, >= 1
- INIT_VAL, 1, value written to every entry during init sweep (weakly not-taken); must be < 2^CTR_W

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- init_done  out  1  high once the init sweep is complete and the table is usable
- rd_en  in  1  lookup request
- rd_idx  in  IDX_W  lookup index
- rd_valid  out  1  rd_ctr/rd_taken valid this cycle
- rd_ctr  out  CTR_W  counter value
- rd_taken  out  1  prediction = MSB of rd_ctr
- upd_en  in  1  update request, no backpressure
- upd_idx  in  IDX_W  update index
- upd_taken  in  1  resolved outcome

Behaviour:
- Reset (rst high at an edge):
  - Outputs: init_done=0, rd_valid=0, rd_ctr=0, rd_taken=0.
  - FSM goes to INIT with ptr=0; U1/U2 valid flags cleared, so in-flight updates are lost.
  - Reset mid-operation always restarts a full sweep.
- FSM INIT:
  - Each edge with rst low: mem[ptr]<=INIT_VAL, ptr<=ptr+1.
  - At the edge that writes ptr==DEPTH-1: state<=RUN, init_done<=1.
  - init_done therefore rises DEPTH edges after the first rst-low edge.
- While in INIT: upd_en is ignored (update dropped, no side effect); rd_en is ignored and rd_valid stays 0.
- FSM RUN: stays in RUN until rst. No other exit.
- Update pipeline:
  - Edge E0: upd_en loads U1 {idx, taken, valid}.
  - Cycle after E0: old = mem[U1.idx]. If U2.valid and U2.idx==U1.idx, old is replaced by U2.val (forwarding).
  - new = taken ? min(old+1, 2^CTR_W-1) : max(old-1, 0). No wrap in either direction.
  - Edge E0+1: U2 <= {U1.idx, new, U1.valid}.
  - Edge E0+2: if U2.valid, mem[U2.idx] <= U2.val.
  - One update can be accepted per cycle. Consecutive updates to the same index compose exactly, with none lost.
- Lookup:
  - Edge E: if RUN and rd_en, then rd_valid<=1 and rd_ctr<=(U2.valid && U2.idx==rd_idx) ? U2.val : mem[rd_idx]. Otherwise rd_valid<=0.
  - rd_ctr and rd_taken hold their last value when rd_valid=0.
  - Latency: 1 cycle.
- Ordering guarantee: an update issued in cycle N is visible to a lookup issued in cycle N+2 or later. A lookup in cycle N+1 returns the pre-update value.
- Simultaneous lookup and update on the same index in the same cycle is legal; the lookup returns the pre-update value.
- Width rules: all counter arithmetic is unsigned CTR_W bits with explicit saturation compares, with no carry-out reliance. Index is used directly, with no modulo logic.

Test Plan:
- Init: IDX_W=4, CTR_W=2, INIT_VAL=1; release rst -> init_done rises exactly 16 cycles later. Lookup of idx 0..15 -> rd_ctr=1, rd_taken=0 each, rd_valid one cycle after rd_en.
- Saturation: 4 taken updates to idx 5, spaced 3 cycles, each followed by a lookup -> 2,3,3,3. Then 5 not-taken -> 2,1,0,0,0; rd_taken 1,0,0,0,0.
- Forwarding: taken updates to idx 7 on 3 consecutive cycles from 1 -> lookup after 2 idle cycles reads 3. Sequence taken, not-taken, taken on idx 9 from 1 -> reads 2.
- Ordering: taken update idx 3 in cycle N -> lookup idx 3 in N+1 reads 1, in N+2 reads 2; same-cycle lookup/update idx 3 reads the pre-update value.
- Reset mid-op: idx 2 at 3, update to idx 2 in U1, rst high 1 cycle -> next cycle rd_valid=0 and init_done=0. After 16 cycles idx 2 reads 1; the in-flight update is not applied.
- Init gating: upd_en to idx 4 and rd_en pulses during INIT -> rd_valid stays 0; after init_done, idx 4 reads 1.
